// File: rtl/collision_event_manager_pkg.sv
// Shared definitions for the collision event manager.
// Holds the game-state encoding, default configuration constants and a
// population-count helper used for kill scoring.
package collision_event_manager_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HIT_GRACE,
    GAME_OVER
  } game_state_t;

  localparam int unsigned SHOTS           = 3;
  localparam int unsigned SCORE_W         = 10;
  localparam int unsigned POINTS_PER_KILL = 5;
  localparam int unsigned START_LIVES     = 3;
  localparam int unsigned GRACE_FRAMES    = 30;

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/collision_event_manager_if.sv
// Bus between the collision detector / frame timing and the event manager.
// Inputs : startOfFrame, startGame, ShotEnemyCollision, ShotBoxCollision,
//          TowerEnemyHUCollision, towerPlayerCollision
// Outputs: shotKill, shotAbsorb, enemyBounce, playerHit, score, lives,
//          invulnerable, gameOver, playing
// master = the side driving collisions and frame timing; slave = the manager.
interface collision_event_manager_if #(
  parameter int unsigned SHOTS   = collision_event_manager_pkg::SHOTS,
  parameter int unsigned SCORE_W = collision_event_manager_pkg::SCORE_W
);
  logic               startOfFrame;
  logic               startGame;
  logic [SHOTS-1:0]   ShotEnemyCollision;
  logic [SHOTS-1:0]   ShotBoxCollision;
  logic               TowerEnemyHUCollision;
  logic               towerPlayerCollision;
  logic [SHOTS-1:0]   shotKill;
  logic [SHOTS-1:0]   shotAbsorb;
  logic               enemyBounce;
  logic               playerHit;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               invulnerable;
  logic               gameOver;
  logic               playing;

  modport master (
    output startOfFrame, startGame, ShotEnemyCollision, ShotBoxCollision,
           TowerEnemyHUCollision, towerPlayerCollision,
    input  shotKill, shotAbsorb, enemyBounce, playerHit, score, lives,
           invulnerable, gameOver, playing
  );

  modport slave (
    input  startOfFrame, startGame, ShotEnemyCollision, ShotBoxCollision,
           TowerEnemyHUCollision, towerPlayerCollision,
    output shotKill, shotAbsorb, enemyBounce, playerHit, score, lives,
           invulnerable, gameOver, playing
  );
endinterface

// File: rtl/collision_event_manager_frame_event_latch.sv
// frame_event_latch: sticky-OR accumulator that is committed once per frame.
// Ports: clk_i, rst_ni (async active-low), en_i (accumulate), commit_i
// (frame boundary), clr_i (synchronous clear), in_i (raw flags),
// acc_o (current accumulation), pulse_o (one-cycle committed events).
module frame_event_latch #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         commit_i,
  input  logic         clr_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] pulse_o
);
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] pulse_q, pulse_d;

  always_comb begin
    acc_d   = acc_q;
    pulse_d = commit_i ? acc_q : '0;
    if (clr_i) begin
      acc_d = '0;
    end else if (commit_i) begin
      // Flags seen on the boundary cycle already belong to the new frame.
      acc_d = en_i ? in_i : '0;
    end else if (en_i) begin
      acc_d = acc_q | in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      pulse_q <= '0;
    end else begin
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
    end
  end

  assign acc_o   = acc_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/collision_event_manager.sv
// collision_event_manager: turns pixel-rate collision flags into per-frame
// single-shot game events, and tracks score, lives and the game state.
// Ports: clk, resetN (async active-low), bus (slave side of
// collision_event_manager_if carrying collision inputs and event outputs).
module collision_event_manager #(
  parameter int unsigned SHOTS           = collision_event_manager_pkg::SHOTS,
  parameter int unsigned SCORE_W         = collision_event_manager_pkg::SCORE_W,
  parameter int unsigned POINTS_PER_KILL = collision_event_manager_pkg::POINTS_PER_KILL,
  parameter int unsigned START_LIVES     = collision_event_manager_pkg::START_LIVES,
  parameter int unsigned GRACE_FRAMES    = collision_event_manager_pkg::GRACE_FRAMES
) (
  input  logic                      clk,
  input  logic                      resetN,
  collision_event_manager_if.slave  bus
);
  import collision_event_manager_pkg::*;

  localparam int unsigned SUM_W     = SCORE_W + 3;
  localparam int unsigned SCORE_MAX = (2 ** SCORE_W) - 1;
  localparam int unsigned GW        = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

  game_state_t        state_q, state_d;
  logic               start_q;
  logic [SCORE_W-1:0] score_q, score_d, score_next;
  logic [1:0]         lives_q, lives_d;
  logic [GW-1:0]      grace_q, grace_d;
  logic [SUM_W-1:0]   score_sum;

  logic               start_rise;
  logic               playing_w;
  logic               in_play;
  logic               commit;

  logic [SHOTS-1:0]   kill_acc, kill_pulse;
  logic [SHOTS-1:0]   absorb_acc_unused, absorb_pulse;
  logic [0:0]         bounce_acc_unused, bounce_pulse;
  logic [0:0]         hit_acc, hit_pulse;

  assign start_rise = bus.startGame & ~start_q;
  assign playing_w  = (state_q == PLAY) || (state_q == HIT_GRACE);
  assign in_play    = (state_q == PLAY);
  assign commit     = bus.startOfFrame & playing_w;

  frame_event_latch #(.W(SHOTS)) u_kill (
    .clk_i(clk), .rst_ni(resetN), .en_i(playing_w), .commit_i(commit),
    .clr_i(~playing_w), .in_i(bus.ShotEnemyCollision),
    .acc_o(kill_acc), .pulse_o(kill_pulse)
  );

  frame_event_latch #(.W(SHOTS)) u_absorb (
    .clk_i(clk), .rst_ni(resetN), .en_i(playing_w), .commit_i(commit),
    .clr_i(~playing_w), .in_i(bus.ShotBoxCollision),
    .acc_o(absorb_acc_unused), .pulse_o(absorb_pulse)
  );

  frame_event_latch #(.W(1)) u_bounce (
    .clk_i(clk), .rst_ni(resetN), .en_i(playing_w), .commit_i(commit),
    .clr_i(~playing_w), .in_i(bus.TowerEnemyHUCollision),
    .acc_o(bounce_acc_unused), .pulse_o(bounce_pulse)
  );

  // Player hits only count in PLAY; held cleared during grace and when idle.
  frame_event_latch #(.W(1)) u_hit (
    .clk_i(clk), .rst_ni(resetN), .en_i(in_play), .commit_i(commit),
    .clr_i(~in_play), .in_i(bus.towerPlayerCollision),
    .acc_o(hit_acc), .pulse_o(hit_pulse)
  );

  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(POINTS_PER_KILL * count_ones(32'(kill_acc)));
    if (score_sum > SUM_W'(SCORE_MAX)) begin
      score_next = '1;
    end else begin
      score_next = score_sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    grace_d = grace_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_rise) begin
          state_d = PLAY;
          lives_d = 2'(START_LIVES);
          score_d = '0;
          grace_d = '0;
        end
      end
      PLAY: begin
        if (commit) begin
          // Kills of the final frame are scored even when the game ends.
          score_d = score_next;
          if (hit_acc[0]) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = GAME_OVER;
            end else if (GRACE_FRAMES != 0) begin
              state_d = HIT_GRACE;
              grace_d = GW'(GRACE_FRAMES);
            end
          end
        end
      end
      HIT_GRACE: begin
        if (commit) begin
          score_d = score_next;
          if (grace_q == '0) begin
            state_d = PLAY;
          end else begin
            grace_d = grace_q - GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      score_q <= '0;
      lives_q <= '0;
      grace_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.startGame;
      score_q <= score_d;
      lives_q <= lives_d;
      grace_q <= grace_d;
    end
  end

  // Kill and absorb pulses come from the same commit, so masking the
  // registered pulses gives kill priority per slot.
  assign bus.shotKill     = kill_pulse;
  assign bus.shotAbsorb   = absorb_pulse & ~kill_pulse;
  assign bus.enemyBounce  = bounce_pulse[0];
  assign bus.playerHit    = hit_pulse[0];
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.invulnerable = (state_q == HIT_GRACE);
  assign bus.gameOver     = (state_q == GAME_OVER);
  assign bus.playing      = playing_w;
endmodule

// File: tb/tb_collision_event_manager.sv
module tb_collision_event_manager;
  localparam int SH  = 3;
  localparam int SW  = 10;
  localparam int PPK = 5;
  localparam int SL  = 3;
  localparam int GF  = 30;
  localparam int SMAX = 1023;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  collision_event_manager_if #(.SHOTS(SH), .SCORE_W(SW)) bus ();

  collision_event_manager #(
    .SHOTS(SH), .SCORE_W(SW), .POINTS_PER_KILL(PPK),
    .START_LIVES(SL), .GRACE_FRAMES(GF)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model: game-level view (0 idle, 1 play, 2 grace, 3 over).
  int m_state, m_score, m_lives, m_grace;
  logic [2:0] f_kill, f_abs;
  logic f_bounce, f_hit, m_prev_sg;
  logic [2:0] e_kill, e_abs;
  logic e_bounce, e_hit;

  function automatic int ones3(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  function automatic logic [22:0] exp_vec();
    return {e_kill, e_abs, e_bounce, e_hit, SW'(m_score), 2'(m_lives),
            m_state == 2, m_state == 3, (m_state == 1) || (m_state == 2)};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {bus.shotKill, bus.shotAbsorb, bus.enemyBounce, bus.playerHit, bus.score,
            bus.lives, bus.invulnerable, bus.gameOver, bus.playing};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_grace = 0;
    f_kill = '0; f_abs = '0; f_bounce = 0; f_hit = 0; m_prev_sg = 0;
    e_kill = '0; e_abs = '0; e_bounce = 0; e_hit = 0;
  endtask

  // One clock cycle of stimulus; the model predicts outputs after the edge.
  task automatic cycle(input logic sof, input logic [2:0] se, input logic [2:0] sb,
                       input logic te, input logic tp, input logic sg);
    int pre;
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.ShotEnemyCollision = se;
    bus.ShotBoxCollision = sb;
    bus.TowerEnemyHUCollision = te;
    bus.towerPlayerCollision = tp;
    bus.startGame = sg;
    pre = m_state;
    e_kill = '0; e_abs = '0; e_bounce = 0; e_hit = 0;
    if (pre == 1 || pre == 2) begin
      if (sof) begin
        e_kill = f_kill;
        e_abs = f_abs & ~f_kill;
        e_bounce = f_bounce;
        e_hit = f_hit;
        m_score = m_score + PPK * ones3(f_kill);
        if (m_score > SMAX) m_score = SMAX;
        if (pre == 1 && f_hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_grace = GF; end
        end else if (pre == 2) begin
          if (m_grace == 0) m_state = 1;
          else m_grace = m_grace - 1;
        end
        f_kill = se; f_abs = sb; f_bounce = te; f_hit = (pre == 1) ? tp : 1'b0;
      end else begin
        f_kill |= se; f_abs |= sb; f_bounce |= te;
        if (pre == 1) f_hit |= tp;
      end
    end
    if (sg && !m_prev_sg && (pre == 0 || pre == 3)) begin
      m_state = 1; m_lives = SL; m_score = 0; m_grace = 0;
    end
    m_prev_sg = sg;
    if (m_state != 1) f_hit = 0;
    if (m_state != 1 && m_state != 2) begin
      f_kill = '0; f_abs = '0; f_bounce = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // A frame of len cycles: random pixel activity inside the given masks
  // (every masked flag appears at least once), then a clean startOfFrame.
  task automatic frame(input int len, input logic [2:0] se_m, input logic [2:0] sb_m,
                       input logic te_m, input logic tp_m);
    int force_at;
    logic [2:0] se, sb;
    logic te, tp;
    force_at = $urandom_range(len - 2, 0);
    for (int c = 0; c < len - 1; c++) begin
      se = se_m & 3'($urandom);
      sb = sb_m & 3'($urandom);
      te = te_m & 1'($urandom);
      tp = tp_m & 1'($urandom);
      if (c == force_at) begin se = se_m; sb = sb_m; te = te_m; tp = tp_m; end
      cycle(1'b0, se, sb, te, tp, 1'b0);
    end
    cycle(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    total++;
    if (obs_vec() !== 23'd0) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", obs_vec(), 23'd0);
    end
    @(negedge clk);
    resetN = 1'b1;
    cycle(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs_vec() !== exp_vec() || bus.playing !== 1'b0) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_start_kill();
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.playing !== 1'b1 || bus.lives !== 2'd3 || bus.score !== 10'd0) begin
      bad++; $display("FAIL start_load play=%b lives=%0d score=%0d want 1/3/0",
                      bus.playing, bus.lives, bus.score);
    end
    repeat (3) cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b101 || bus.score !== 10'd10) begin
      bad++; $display("FAIL kill_commit kill=%b score=%0d want 101/10", bus.shotKill, bus.score);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL kill_model got=%h want=%h", obs_vec(), exp_vec());
    end
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b000) begin
      bad++; $display("FAIL kill_width got=%b want=000", bus.shotKill);
    end
    frame(8, 3'b000, 3'b000, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b000 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL kill_no_repeat got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_priority();
    frame(8, 3'b010, 3'b010, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b010 || bus.shotAbsorb !== 3'b000 || bus.score !== 10'd15) begin
      bad++; $display("FAIL prio kill=%b absorb=%b score=%0d want 010/000/15",
                      bus.shotKill, bus.shotAbsorb, bus.score);
    end
    frame(8, 3'b000, 3'b100, 1'b1, 1'b0);
    total++;
    if (bus.shotAbsorb !== 3'b100 || bus.enemyBounce !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL absorb_bounce got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_ignore_start();
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.score !== 10'd15 || bus.lives !== 2'd3 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL start_in_play got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sof_cycle();
    repeat (5) cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b000 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL sof_same_cycle got=%h want=%h", obs_vec(), exp_vec());
    end
    frame(8, 3'b000, 3'b000, 1'b0, 1'b0);
    total++;
    if (bus.shotKill !== 3'b001 || bus.score !== 10'd20) begin
      bad++; $display("FAIL sof_next_frame kill=%b score=%0d want 001/20", bus.shotKill, bus.score);
    end
  endtask

  task automatic test_grace();
    frame(8, 3'b000, 3'b000, 1'b0, 1'b1);
    total++;
    if (bus.playerHit !== 1'b1 || bus.lives !== 2'd2 || bus.invulnerable !== 1'b1) begin
      bad++; $display("FAIL hit hit=%b lives=%0d inv=%b want 1/2/1",
                      bus.playerHit, bus.lives, bus.invulnerable);
    end
    for (int f = 1; f <= 31; f++) begin
      frame(8, (f == 5) ? 3'b011 : 3'b000, 3'b000, 1'b0, f == 10);
      total++;
      if (obs_vec() !== exp_vec() || bus.invulnerable !== (f <= 30)) begin
        bad++; $display("FAIL grace_frame%0d got=%h want=%h", f, obs_vec(), exp_vec());
      end
      if (f == 10) begin
        total++;
        if (bus.playerHit !== 1'b0 || bus.lives !== 2'd2) begin
          bad++; $display("FAIL grace_hit_ignored hit=%b lives=%0d want 0/2", bus.playerHit, bus.lives);
        end
      end
    end
  endtask

  task automatic test_game_over();
    int frozen;
    frame(8, 3'b000, 3'b000, 1'b0, 1'b1);
    total++;
    if (bus.lives !== 2'd1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL second_hit got=%h want=%h", obs_vec(), exp_vec());
    end
    repeat (31) frame(8, 3'b000, 3'b000, 1'b0, 1'b0);
    frame(8, 3'b100, 3'b000, 1'b0, 1'b1);
    total++;
    if (bus.lives !== 2'd0 || bus.gameOver !== 1'b1 || bus.playing !== 1'b0 ||
        bus.score !== 10'd35 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL final_hit got=%h want=%h", obs_vec(), exp_vec());
    end
    frozen = m_score;
    frame(8, 3'b111, 3'b111, 1'b1, 1'b1);
    total++;
    if (bus.shotKill !== 3'b000 || bus.playerHit !== 1'b0 || bus.score !== SW'(frozen) ||
        obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL over_frozen got=%h want=%h", obs_vec(), exp_vec());
    end
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.lives !== 2'd3 || bus.score !== 10'd0 || bus.playing !== 1'b1 || bus.gameOver !== 1'b0) begin
      bad++; $display("FAIL restart lives=%0d score=%0d play=%b want 3/0/1",
                      bus.lives, bus.score, bus.playing);
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 68; f++) begin
      frame(5, 3'b111, 3'b000, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL sat_frame%0d got=%h want=%h", f, obs_vec(), exp_vec());
      end
    end
    total++;
    if (bus.score !== 10'd1020) begin
      bad++; $display("FAIL sat_preset got=%0d want=1020", bus.score);
    end
    frame(5, 3'b111, 3'b000, 1'b0, 1'b0);
    total++;
    if (bus.score !== 10'd1023) begin
      bad++; $display("FAIL sat_clip got=%0d want=1023", bus.score);
    end
    frame(5, 3'b001, 3'b000, 1'b0, 1'b0);
    total++;
    if (bus.score !== 10'd1023 || bus.shotKill !== 3'b001) begin
      bad++; $display("FAIL sat_hold score=%0d kill=%b want 1023/001", bus.score, bus.shotKill);
    end
  endtask

  task automatic test_random();
    int len, cnt;
    logic sof, sg, te, tp;
    logic [2:0] se, sb;
    len = 6; cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      sof = (cnt == len - 1);
      se = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'b000;
      sb = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'b000;
      te = ($urandom_range(5, 0) == 0);
      tp = ($urandom_range(40, 0) == 0);
      sg = !sof && ($urandom_range(30, 0) == 0);
      cycle(sof, se, sb, te, tp, sg);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      cnt++;
      if (sof) begin cnt = 0; len = $urandom_range(9, 4); end
    end
  endtask

  task automatic test_reset_mid_frame();
    if (m_state != 1 && m_state != 2) begin
      cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) cycle(1'b0, 3'b110, 3'b001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== 23'd0) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs_vec(), 23'd0);
    end
    @(negedge clk);
    resetN = 1'b1;
    cycle(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_vec() !== 23'd0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_no_pulse got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.startOfFrame = 1'b0;
    bus.startGame = 1'b0;
    bus.ShotEnemyCollision = '0;
    bus.ShotBoxCollision = '0;
    bus.TowerEnemyHUCollision = 1'b0;
    bus.towerPlayerCollision = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_start_kill();
    test_priority();
    test_ignore_start();
    test_sof_cycle();
    test_grace();
    test_game_over();
    test_saturation();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
